// File: rtl/dmem_io_pkg.sv
// Shared constants for the data-memory / UART I/O block: register map,
// STATUS bit positions and the transmitter state encoding.
package dmem_io_pkg;

  localparam logic [31:0] ADDR_TXDATA = 32'h1000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h1000_0004;
  localparam logic [31:0] ADDR_BAUD   = 32'h1000_0008;
  localparam logic [31:0] ADDR_CYCLE  = 32'h1000_000C;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // All accesses are word-wide, so the byte offset is dropped before decoding.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_io_sync_fifo.sv
// Single-clock FIFO (DEPTH a power of two, >= 2) with a show-ahead head word.
// A push into a full FIFO succeeds only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && full && !pop_ok;
  assign pop_data = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dmem_io.sv
// Data RAM plus memory-mapped UART transmitter (TXDATA/STATUS/BAUD/CYCLE).
// Define DMEM_IO_CYCLE_CNT_EN to build the free-running CYCLE counter.
module dmem_io
  import dmem_io_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int BAUD_DIV_RST = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] rdata,
  output logic        uart_tx
);

  localparam int RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]       ram_mem [DEPTH_WORDS];
  logic [31:0]       word;
  logic              ram_hit;
  logic [RAM_AW-1:0] ram_idx;

  logic [15:0] baud_reg;
  logic        overflow_reg;
  logic [31:0] cycle_val;
  logic [3:0]  status_bits;

  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_ovf;

  tx_state_t   state_reg;
  logic [15:0] baud_cnt_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic        uart_tx_reg;
  logic        tx_busy;
  logic        bit_done;
  logic [15:0] baud_reload;

  assign word    = word_addr(addr);
  assign ram_hit = (addr < 32'(4 * DEPTH_WORDS));
  assign ram_idx = addr[RAM_AW+1:2];

  always_ff @(posedge clk) begin
    if (mem_write && ram_hit) ram_mem[ram_idx] <= wdata;
  end

  always_comb begin
    status_bits             = '0;
    status_bits[STAT_FULL]  = fifo_full;
    status_bits[STAT_EMPTY] = fifo_empty;
    status_bits[STAT_BUSY]  = tx_busy;
    status_bits[STAT_OVF]   = overflow_reg;
  end

  always_comb begin
    rdata = '0;
    if (mem_read) begin
      if (ram_hit) begin
        rdata = ram_mem[ram_idx];
      end else begin
        case (word)
          ADDR_STATUS: rdata = {28'd0, status_bits};
          ADDR_BAUD:   rdata = {16'd0, baud_reg};
          ADDR_CYCLE:  rdata = cycle_val;
          default:     rdata = '0;
        endcase
      end
    end
  end

  // Overflow set wins over a simultaneous software clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_reg     <= 16'(BAUD_DIV_RST);
      overflow_reg <= 1'b0;
    end else begin
      if (mem_write && word == ADDR_BAUD)
        baud_reg <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
      if (fifo_ovf)
        overflow_reg <= 1'b1;
      else if (mem_write && word == ADDR_STATUS && wdata[STAT_OVF])
        overflow_reg <= 1'b0;
    end
  end

`ifdef DMEM_IO_CYCLE_CNT_EN
  logic [31:0] cycle_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_reg <= '0;
    else     cycle_reg <= cycle_reg + 32'd1;
  end

  assign cycle_val = cycle_reg;
`else
  assign cycle_val = '0;
`endif

  assign fifo_push = mem_write && (word == ADDR_TXDATA);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (wdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf)
  );

  // The bit length is sampled when each bit starts, so BAUD writes never stretch the current bit.
  assign baud_reload = baud_reg - 16'd1;
  assign bit_done    = (baud_cnt_reg == 16'd0);
  assign tx_busy     = (state_reg != IDLE);
  assign uart_tx     = uart_tx_reg;
  assign fifo_pop    = !fifo_empty && ((state_reg == IDLE) || (state_reg == STOP && bit_done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      uart_tx_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          uart_tx_reg <= 1'b1;
          if (!fifo_empty) begin
            state_reg    <= START;
            uart_tx_reg  <= 1'b0;
            shift_reg    <= fifo_rdata;
            baud_cnt_reg <= baud_reload;
          end
        end
        START: begin
          if (bit_done) begin
            state_reg    <= DATA;
            uart_tx_reg  <= shift_reg[0];
            shift_reg    <= {1'b0, shift_reg[7:1]};
            bit_cnt_reg  <= '0;
            baud_cnt_reg <= baud_reload;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt_reg <= baud_reload;
            if (bit_cnt_reg == 3'd7) begin
              state_reg   <= STOP;
              uart_tx_reg <= 1'b1;
            end else begin
              uart_tx_reg <= shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[7:1]};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (!fifo_empty) begin
              state_reg    <= START;
              uart_tx_reg  <= 1'b0;
              shift_reg    <= fifo_rdata;
              baud_cnt_reg <= baud_reload;
            end else begin
              state_reg   <= IDLE;
              uart_tx_reg <= 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 16'd1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          uart_tx_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_io.md
DMEM_IO -- requirements
Module: dmem_io

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit data RAM words.
REQ-002 Parameter FIFO_DEPTH, default 8, UART transmit FIFO entries (power of two).
REQ-003 Parameter BAUD_DIV_RST, default 868, reset value of the baud divisor in clocks per bit.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 addr  input  32  byte address, driven by core alu_result.
REQ-007 wdata  input  32  store data, driven by core DataWM.
REQ-008 mem_write  input  1  store strobe, driven by core MemWrite.
REQ-009 mem_read  input  1  load strobe, driven by core MemRead.
REQ-010 rdata  output  32  load data, drives core dataR.
REQ-011 uart_tx  output  1  serial transmit line, idle high.

Function
REQ-012 Accesses shall be word-only; addr[1:0] is ignored.
REQ-013 Address map: RAM 0x0000_0000 to 4*DEPTH_WORDS-1; TXDATA 0x1000_0000; STATUS 0x1000_0004; BAUD 0x1000_0008; CYCLE 0x1000_000C.
REQ-014 rdata shall be combinational in the same cycle as addr when mem_read=1, and 0 when mem_read=0 or the address is unmapped.
REQ-015 RAM writes shall commit on the rising edge when mem_write=1 and addr is in RAM range.
REQ-016 Writes to unmapped addresses or read-only registers shall be ignored.
REQ-017 A TXDATA write shall push wdata[7:0] into the FIFO; TXDATA reads return 0.
REQ-018 A push when the FIFO is full and not popping shall be dropped and shall set the sticky overflow flag.
REQ-019 A push and a pop in the same cycle with the FIFO full shall both succeed, leaving the count unchanged.
REQ-020 STATUS read: bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow, other bits 0.
REQ-021 A STATUS write with wdata[3]=1 shall clear overflow; an overflow set in the same cycle shall take priority.
REQ-022 BAUD holds a 16-bit divisor; a write stores wdata[15:0], with 0 stored as 1; reads zero-extend the stored value.
REQ-023 TX FSM states IDLE, START, DATA, STOP.
REQ-024 In IDLE with the FIFO not empty, the FSM shall pop a byte on the edge and enter START.
REQ-025 uart_tx shall be 0 in START, data bit i (LSB first) in DATA, and 1 in STOP and IDLE.
REQ-026 Each bit shall last exactly BAUD clocks; DATA holds 8 bits; STOP returns to IDLE.
REQ-027 Back-to-back frames shall have no idle gap when the FIFO is non-empty at the end of STOP.
REQ-028 A BAUD write shall affect only the next bit period, not the current one.
REQ-029 tx_busy shall be 1 in every state except IDLE.
REQ-030 Latency: TXDATA write at edge N into an idle, empty FIFO produces the start bit from edge N+1.

Reset
REQ-031 On rst: FSM=IDLE, uart_tx=1, FIFO empty, overflow=0, BAUD=BAUD_DIV_RST, CYCLE=0.
REQ-032 Reset mid-frame shall abort the frame immediately and discard FIFO contents.
REQ-033 RAM contents are not reset; rdata remains combinational during reset.

Configuration
REQ-034 With macro DMEM_IO_CYCLE_CNT_EN defined: CYCLE is a free-running 32-bit counter, incrementing every clock, wrapping at 2^32, read-only.
REQ-035 Without DMEM_IO_CYCLE_CNT_EN: no counter logic, and CYCLE reads 0.

Structure
REQ-036 Package dmem_io_pkg shall hold address constants, the STATUS bit indices, and the tx_state_t enum.
REQ-037 The FIFO shall be a sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty), instantiated once.

Verification
REQ-038 Write 0xDEADBEEF to 0x100, then read 0x100 and 0x103 -> rdata 0xDEADBEEF both times; read 0x2000_0000 -> 0.
REQ-039 BAUD=4, write 0x55 to TXDATA -> uart_tx low for 4 cycles from edge N+1, then 1,0,1,0,1,0,1,0, then high; tx_busy 0 after 40 cycles.
REQ-040 BAUD=4, 10 back-to-back TXDATA writes -> 9 bytes accepted, STATUS=0x0D; write 0x8 to STATUS -> overflow 0.
REQ-041 Assert rst during the DATA state -> uart_tx=1 immediately, STATUS=0x02, BAUD reads 868.
REQ-042 Write 0 to BAUD -> BAUD reads 1, and each transmitted bit lasts 1 clock.
REQ-043 After reset, read CYCLE after 100 clocks -> 100 with DMEM_IO_CYCLE_CNT_EN defined, 0 without it.
